// File: rtl/axi_stream_insert_ctrl.sv
// Prepends a 1..N byte header to each AXI-Stream packet, realigning the payload
// so that the merged packet is byte-contiguous from the MSB lane of its first beat.
module axi_stream_insert_ctrl #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,

   input  logic                    valid_in,
   output logic                    ready_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,

   input  logic                    valid_insert,
   output logic                    ready_insert,
   input  logic [DATA_WD-1:0]      data_insert,
   input  logic [DATA_BYTE_WD-1:0] keep_insert,
   input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,

   output logic                    valid_out,
   input  logic                    ready_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out
);

   localparam int N  = DATA_BYTE_WD;
   localparam int HW = BYTE_CNT_WD + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_TAIL   = 2'd2;

   logic [1:0]         state;
   logic [DATA_WD-1:0] res_data;
   logic [N-1:0]       res_keep;
   logic [HW-1:0]      hdr_len;

   logic               out_free;
   logic               hdr_fire;
   logic               data_fire;
   logic               tail_fire;
   logic               tail_needed;
   logic [N-1:0]       low_mask;
   logic [DATA_WD-1:0] src_data;
   logic [N-1:0]       src_keep;
   logic [DATA_WD-1:0] merged_data;
   logic [N-1:0]       merged_keep;
   logic               unused_keep_insert;

   // byte_insert_cnt alone defines the header length.
   assign unused_keep_insert = &{1'b0, keep_insert};

   assign out_free     = !valid_out || ready_out;
   assign ready_insert = (state == S_IDLE);
   assign ready_in     = (state == S_STREAM) && out_free;

   assign hdr_fire  = valid_insert && ready_insert;
   assign data_fire = valid_in && ready_in;
   assign tail_fire = (state == S_TAIL) && out_free;

   // Residual sits in the low H lanes; shifting {residual, incoming} right by H
   // bytes puts the residual on top and the incoming top N-H bytes below it.
   // The tail beat is the same shift with an empty incoming word.
   assign src_data    = (state == S_TAIL) ? '0 : data_in;
   assign src_keep    = (state == S_TAIL) ? '0 : keep_in;
   assign merged_data = DATA_WD'({res_data, src_data} >> {hdr_len, 3'b000});
   assign merged_keep = N'({res_keep, src_keep} >> hdr_len);

   assign low_mask    = ~({N{1'b1}} << hdr_len);
   assign tail_needed = |(keep_in & low_mask);

   // NOTE: registers use non-blocking assignments so every block samples the
   // pre-edge values of the others, regardless of evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         // NOTE: the residual is real packet state, so it is cleared on reset to
         // keep a killed packet from leaking into the next one.
         res_data <= '0;
         res_keep <= '0;
         hdr_len  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (hdr_fire) begin
                  res_data <= data_insert;
                  res_keep <= '1;
                  hdr_len  <= HW'(byte_insert_cnt) + HW'(1);
                  state    <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (data_fire) begin
                  res_data <= data_in;
                  res_keep <= keep_in;
                  if (last_in) state <= tail_needed ? S_TAIL : S_IDLE;
               end
            end
            S_TAIL: begin
               if (tail_fire) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         keep_out  <= '0;
         last_out  <= 1'b0;
      end else if (data_fire || tail_fire) begin
         valid_out <= 1'b1;
         data_out  <= merged_data;
         keep_out  <= merged_keep;
         last_out  <= tail_fire || (last_in && !tail_needed);
      end else if (ready_out) begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_stream_insert_ctrl.sv
// Bench for axi_stream_insert_ctrl: packets are modelled as plain byte lists,
// re-chunked into expected beats and scoreboarded against every output handshake.
module tb_axi_stream_insert_ctrl;

   localparam int DW = 32;
   localparam int N  = 4;

   typedef struct {
      logic [DW-1:0] data;
      logic [N-1:0]  keep;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid_in = 1'b0;
   logic          ready_in;
   logic [DW-1:0] data_in = '0;
   logic [N-1:0]  keep_in = '0;
   logic          last_in = 1'b0;
   logic          valid_insert = 1'b0;
   logic          ready_insert;
   logic [DW-1:0] data_insert = '0;
   logic [N-1:0]  keep_insert = '0;
   logic [1:0]    byte_insert_cnt = '0;
   logic          valid_out;
   logic          ready_out = 1'b1;
   logic [DW-1:0] data_out;
   logic [N-1:0]  keep_out;
   logic          last_out;

   int errors = 0;
   int checks = 0;
   int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by the test

   beat_t      exp_q[$];
   beat_t      mdl_q[$];
   logic [7:0] dat_bytes[$];

   axi_stream_insert_ctrl #(.DATA_WD(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
      .keep_in(keep_in), .last_in(last_in),
      .valid_insert(valid_insert), .ready_insert(ready_insert),
      .data_insert(data_insert), .keep_insert(keep_insert),
      .byte_insert_cnt(byte_insert_cnt),
      .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
      .keep_out(keep_out), .last_out(last_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] kmask(input logic [N-1:0] k);
      logic [DW-1:0] m = '0;
      for (int i = 0; i < N; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   // Merged packet = header bytes (lane h-1 first) followed by payload bytes,
   // chunked into N-byte beats filled from the MSB lane.
   task automatic build_model(input int h, input logic [DW-1:0] hdr);
      logic [7:0] s[$];
      beat_t b;
      mdl_q.delete();
      for (int i = h - 1; i >= 0; i--) s.push_back(hdr[8*i +: 8]);
      foreach (dat_bytes[i]) s.push_back(dat_bytes[i]);
      for (int bi = 0; bi * N < s.size(); bi++) begin
         b.data = '0;
         b.keep = '0;
         for (int l = 0; l < N; l++) begin
            if (bi * N + l < s.size()) begin
               b.data[8*(N-1-l) +: 8] = s[bi*N + l];
               b.keep[N-1-l] = 1'b1;
            end
         end
         b.last = (bi * N + N >= s.size());
         mdl_q.push_back(b);
      end
   endtask

   task automatic pin_model(input string name, input int idx,
                            input logic [DW-1:0] d, input logic [N-1:0] k, input logic l);
      if (idx < mdl_q.size()) begin
         check({name, "_data"}, 64'(mdl_q[idx].data), 64'(d));
         check({name, "_keep"}, 64'(mdl_q[idx].keep), 64'(k));
         check({name, "_last"}, 64'(mdl_q[idx].last), 64'(l));
      end else begin
         check({name, "_missing"}, 64'(mdl_q.size()), 64'(idx + 1));
      end
   endtask

   task automatic push_beat(input logic [DW-1:0] d, input logic [N-1:0] k, input logic l);
      beat_t b;
      b.data = d;
      b.keep = k;
      b.last = l;
      exp_q.push_back(b);
   endtask

   // Called at posedge+1 with a valid raised; returns at posedge+1 after the handshake.
   task automatic wait_hs(input int on_data, input string name);
      int  n = 0;
      bit  got = 1'b0;
      while (!got && n < 2000) begin
         @(negedge clk);
         got = on_data ? ready_in : ready_insert;
         @(posedge clk);
         #1;
         n++;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no handshake after %0d cycles, required 1", name, n);
      end
   endtask

   task automatic send_packet(input int cnt, input logic [DW-1:0] hdr, input int gap);
      int nd = dat_bytes.size();
      int nb = (nd + N - 1) / N;
      int kept;
      data_insert     = hdr;
      byte_insert_cnt = 2'(cnt);
      keep_insert     = 4'($urandom);
      valid_insert    = 1'b1;
      wait_hs(0, "hdr");
      valid_insert    = 1'b0;
      for (int b = 0; b < nb; b++) begin
         while ($urandom_range(99) < gap) begin
            @(posedge clk);
            #1;
         end
         kept = (b == nb - 1) ? nd - N * b : N;
         for (int l = 0; l < N; l++)
            data_in[8*(N-1-l) +: 8] = (l < kept) ? dat_bytes[N*b + l] : 8'($urandom);
         keep_in  = 4'(4'hF << (N - kept));
         last_in  = (b == nb - 1);
         valid_in = 1'b1;
         wait_hs(1, "data");
         valid_in = 1'b0;
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic set_bytes(input logic [63:0] v, input int n);
      dat_bytes.delete();
      for (int i = 0; i < n; i++) dat_bytes.push_back(v[8*(n-1-i) +: 8]);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) ready_out = 1'b1;
         else if (ready_mode == 1) ready_out = ($urandom_range(99) < 60);
      end
   end

   always @(negedge clk) begin
      beat_t e;
      logic [DW-1:0] m;
      if (rst_n && valid_out && ready_out) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data 0x%0h keep 0x%0h, required no beat",
                     data_out, keep_out);
         end else begin
            e = exp_q.pop_front();
            m = kmask(e.keep);
            check("out_data", 64'(data_out & m), 64'(e.data & m));
            check("out_keep", 64'(keep_out), 64'(e.keep));
            check("out_last", 64'(last_out), 64'(e.last));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      int cnt;
      int nd;
      logic [DW-1:0] hdr;

      #2;
      check("rst_valid_out", 64'(valid_out), 64'd0);
      check("rst_data_out", 64'(data_out), 64'd0);
      check("rst_keep_out", 64'(keep_out), 64'd0);
      check("rst_last_out", 64'(last_out), 64'd0);
      check("rst_ready_in", 64'(ready_in), 64'd0);
      check("rst_ready_insert", 64'(ready_insert), 64'd1);
      #20 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // One-byte header, 8-byte payload: three beats with a one-byte tail.
      set_bytes(64'h1122334455667788, 8);
      build_model(1, 32'h000000AA);
      pin_model("m29_b0", 0, 32'hAA112233, 4'b1111, 1'b0);
      pin_model("m29_b1", 1, 32'h44556677, 4'b1111, 1'b0);
      pin_model("m29_b2", 2, 32'h88000000, 4'b1000, 1'b1);
      push_beat(32'hAA112233, 4'b1111, 1'b0);
      push_beat(32'h44556677, 4'b1111, 1'b0);
      push_beat(32'h88000000, 4'b1000, 1'b1);
      send_packet(0, 32'hFFFFFFAA, 0);
      drain("d29");

      // Same packet with the sink stalled around the first output beat.
      push_beat(32'hAA112233, 4'b1111, 1'b0);
      push_beat(32'h44556677, 4'b1111, 1'b0);
      push_beat(32'h88000000, 4'b1000, 1'b1);
      ready_mode = 2;
      ready_out  = 1'b0;
      fork
         send_packet(0, 32'h000000AA, 0);
         begin
            int n = 0;
            while (!valid_out && n < 200) begin
               @(negedge clk);
               n++;
            end
            for (int i = 0; i < 3; i++) begin
               check("stall_valid", 64'(valid_out), 64'd1);
               check("stall_data", 64'(data_out), 64'hAA112233);
               check("stall_keep", 64'(keep_out), 64'hF);
               check("stall_ready_in", 64'(ready_in), 64'd0);
               if (i < 2) @(negedge clk);
            end
            @(posedge clk);
            #1;
            ready_out  = 1'b1;
            ready_mode = 0;
         end
      join
      drain("d32");

      // Data offered before any header must wait; two-byte header absorbs it all.
      set_bytes(64'h1122, 2);
      build_model(2, 32'h0000BEEF);
      pin_model("m30_b0", 0, 32'hBEEF1122, 4'b1111, 1'b1);
      check("m30_beats", 64'(mdl_q.size()), 64'd1);
      push_beat(32'hBEEF1122, 4'b1111, 1'b1);
      data_in  = 32'h11223344;
      keep_in  = 4'b1100;
      last_in  = 1'b1;
      valid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("pre_hdr_ready_in", 64'(ready_in), 64'd0);
      end
      @(posedge clk);
      #1;
      data_insert     = 32'h0000BEEF;
      byte_insert_cnt = 2'd1;
      valid_insert    = 1'b1;
      wait_hs(0, "hdr33");
      valid_insert = 1'b0;
      @(negedge clk);
      check("post_hdr_ready_in", 64'(ready_in), 64'd1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      @(negedge clk);
      check("no_tail_idle", 64'(ready_insert), 64'd1);
      drain("d30");

      // Full-width header: payload passes through one beat behind.
      set_bytes(64'h1122, 2);
      build_model(4, 32'hA1B2C3D4);
      pin_model("m31_b0", 0, 32'hA1B2C3D4, 4'b1111, 1'b0);
      pin_model("m31_b1", 1, 32'h11220000, 4'b1100, 1'b1);
      push_beat(32'hA1B2C3D4, 4'b1111, 1'b0);
      push_beat(32'h11220000, 4'b1100, 1'b1);
      send_packet(3, 32'hA1B2C3D4, 0);
      drain("d31");

      // Reset in the middle of a packet.
      push_beat(32'hAA112233, 4'b1111, 1'b0);
      data_insert     = 32'h000000AA;
      byte_insert_cnt = 2'd0;
      valid_insert    = 1'b1;
      wait_hs(0, "hdr34");
      valid_insert = 1'b0;
      data_in  = 32'h11223344;
      keep_in  = 4'b1111;
      last_in  = 1'b0;
      valid_in = 1'b1;
      wait_hs(1, "d34a");
      data_in = 32'h55667788;
      wait_hs(1, "d34b");
      valid_in = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid_out", 64'(valid_out), 64'd0);
      check("mid_rst_data_out", 64'(data_out), 64'd0);
      check("mid_rst_keep_out", 64'(keep_out), 64'd0);
      check("mid_rst_last_out", 64'(last_out), 64'd0);
      check("mid_rst_ready_in", 64'(ready_in), 64'd0);
      check("mid_rst_ready_insert", 64'(ready_insert), 64'd1);
      exp_q.delete();
      #15 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_quiet", 64'(valid_out), 64'd0);
      end
      @(posedge clk);
      #1;
      set_bytes(64'h1122, 2);
      build_model(4, 32'hA1B2C3D4);
      foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
      send_packet(3, 32'hA1B2C3D4, 0);
      drain("d34");

      // Randomized packets, back to back, with random sink back-pressure.
      for (int p = 0; p < 60; p++) begin
         cnt = $urandom_range(3);
         hdr = $urandom;
         nd  = $urandom_range(1, 13);
         dat_bytes.delete();
         for (int i = 0; i < nd; i++) dat_bytes.push_back(8'($urandom));
         ready_mode = $urandom_range(1);
         build_model(cnt + 1, hdr);
         foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
         send_packet(cnt, hdr, $urandom_range(30));
      end
      ready_mode = 0;
      drain("rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_stream_insert_ctrl.md
AXI_STREAM_INSERT_CTRL -- requirements
Module: axi_stream_insert_ctrl

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, stream data width in bits.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, byte lanes (N below).
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), header byte-count width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports valid_in/ready_in  input/output  1  data-stream handshake.
REQ-007 SHALL have ports data_in  input  DATA_WD; keep_in  input  N; last_in  input  1.
REQ-008 SHALL have ports valid_insert/ready_insert  input/output  1  header handshake.
REQ-009 SHALL have ports data_insert  input  DATA_WD; keep_insert  input  N; byte_insert_cnt  input  BYTE_CNT_WD.
REQ-010 SHALL have ports valid_out/ready_out  output/input  1  merged-stream handshake.
REQ-011 SHALL have ports data_out  output  DATA_WD; keep_out  output  N; last_out  output  1.

Function
REQ-012 SHALL use byte order MSB lane first; data_in non-last beats keep all-ones, last beat keep MSB-aligned contiguous, at least 1 byte.
REQ-013 SHALL treat header as H = byte_insert_cnt+1 valid bytes in the LSB lanes; keep_insert is ignored (byte_insert_cnt authoritative).
REQ-014 SHALL implement states IDLE, STREAM, TAIL; reset state IDLE.
REQ-015 IDLE: ready_insert=1, ready_in=0; header handshake stores the H header bytes as residual, latches H, moves to STREAM.
REQ-016 STREAM: ready_insert=0; ready_in = !valid_out || ready_out.
REQ-017 On each STREAM data handshake SHALL load the output register: data_out = {residual H bytes, data_in top N-H bytes}; keep_out = {H ones, keep_in[N-1:H]}; new residual = data_in low H bytes, residual keep = keep_in[H-1:0].
REQ-018 H=N: merged beat = full residual only; data_in becomes residual entirely (one-beat delay passthrough).
REQ-019 On last_in handshake: if keep_in[H-1:0]==0 SHALL set last_out=1 on that beat and go IDLE; else last_out=0 and go TAIL.
REQ-020 TAIL: ready_in=0, ready_insert=0; when !valid_out || ready_out SHALL load data_out high H lanes = residual, keep_out = {residual keep, zeros}, last_out=1, then go IDLE.
REQ-021 Output register SHALL hold data_out/keep_out/last_out/valid_out stable while valid_out && !ready_out.
REQ-022 valid_out SHALL clear when ready_out accepts and no new beat loads the same cycle.
REQ-023 Latency: output beat valid the cycle after the producing data handshake; sustained 1 beat/clock in STREAM with ready_out=1.
REQ-024 Data arriving in IDLE SHALL stall (ready_in=0) until a header is accepted; headers in STREAM/TAIL SHALL stall (ready_insert=0).
REQ-025 IDLE with a pending output beat SHALL still accept the next header; that header's first merged beat waits for the output register.
REQ-026 Unkept output lanes are don't-care; checkers compare only kept bytes.

Reset
REQ-027 While rst_n=0: valid_out=0, data_out=0, keep_out=0, last_out=0, residual=0, state IDLE, ready_in=0, ready_insert=1.
REQ-028 Reset asserted mid-packet SHALL discard residual and partial packet; no output beat after release until a new header and data arrive.

Verification (N=4)
REQ-029 cnt=0, header 0x000000AA; data 0x11223344, 0x55667788 last keep 1111 -> out 0xAA112233/1111, 0x44556677/1111, 0x88xxxxxx/1000 last.
REQ-030 cnt=1, header 0x0000BEEF; data 0x11223344 keep 1100 last -> single beat 0xBEEF1122/1111 last, no tail, back to IDLE.
REQ-031 cnt=3, header 0xA1B2C3D4; data 0x1122xxxx keep 1100 last -> 0xA1B2C3D4/1111 not last, then 0x1122xxxx/1100 last.
REQ-032 Scenario REQ-029 with ready_out low 3 cycles after first output -> outputs frozen, ready_in=0, all three beats delivered, no loss/duplication.
REQ-033 valid_in=1 before any header -> ready_in=0 until header handshake; ready_in=1 the following cycle.
REQ-034 rst_n pulsed low mid-packet -> all outputs 0 immediately, ready_insert=1; next header+packet processed correctly.
